// File: rtl/vec_store_unit.sv
// Vector store unit: copies one vector register to memory as a burst of
// 32-bit word writes.
//
// A store request (start, vreg, base_addr) is checked in idle; a legal
// request latches the register index and base address, snapshots the
// register-file read data into a holding buffer, then emits one word write
// per beat. Each beat waits for mem_ready before the next beat is issued.
// An illegal request (register index out of range or unaligned base) gives
// a one-cycle error pulse and issues no writes.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      store request, only honoured while idle
//   vreg       source vector register index (sampled with start)
//   base_addr  destination byte address, must be word aligned
//   busy       store in progress
//   done       one-cycle pulse when the last beat has been accepted
//   error      one-cycle pulse after a rejected request
//   rf_ra      register-file read address (latched vreg)
//   rf_rd      register-file read data, lane 0 in the low bits
//   mem_we     word write request
//   mem_addr   word write byte address
//   mem_wd     word write data
//   mem_ready  memory accepts the current beat
module vec_store_unit #(
    parameter int unsigned LANES      = 16,
    parameter int unsigned DATAWIDTH  = 8,
    parameter int unsigned REGSIZE    = 15,
    parameter int unsigned REGSIZEINT = 4,
    parameter int unsigned ADDRWIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [REGSIZEINT-1:0]      vreg,
    input  logic [ADDRWIDTH-1:0]       base_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [REGSIZEINT-1:0]      rf_ra,
    input  logic [LANES*DATAWIDTH-1:0] rf_rd,
    output logic                       mem_we,
    output logic [ADDRWIDTH-1:0]       mem_addr,
    output logic [31:0]                mem_wd,
    input  logic                       mem_ready
);

    localparam int unsigned VecBits  = LANES * DATAWIDTH;
    localparam int unsigned NumBeats = VecBits / 32;
    localparam int unsigned BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StWrite,
        StDone
    } state_e;

    state_e                    state_q;
    logic [REGSIZEINT-1:0]     vreg_q;
    logic [ADDRWIDTH-1:0]      base_q;
    // Buffer viewed as words so that word k is the data for beat k.
    logic [NumBeats-1:0][31:0] buf_q;
    logic [BeatW-1:0]          beat_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      error_q;
    logic                      we_q;

    logic req_ok;
    logic last_beat;

    assign req_ok    = (32'(vreg) < REGSIZE) && (base_addr[1:0] == 2'b00);
    assign last_beat = (beat_q == BeatW'(NumBeats - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            vreg_q  <= '0;
            base_q  <= '0;
            buf_q   <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (req_ok) begin
                            vreg_q  <= vreg;
                            base_q  <= base_addr;
                            busy_q  <= 1'b1;
                            state_q <= StCapture;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                StCapture: begin
                    // rf_ra has been driven from vreg_q for this whole cycle,
                    // so rf_rd now holds the requested register.
                    buf_q   <= rf_rd;
                    beat_q  <= '0;
                    we_q    <= 1'b1;
                    state_q <= StWrite;
                end
                StWrite: begin
                    if (mem_ready) begin
                        beat_q <= beat_q + BeatW'(1);
                        if (last_beat) begin
                            we_q    <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign mem_we   = we_q;
    assign rf_ra    = vreg_q;
    // Address arithmetic wraps naturally at ADDRWIDTH bits.
    assign mem_addr = base_q + ADDRWIDTH'({beat_q, 2'b00});
    assign mem_wd   = buf_q[beat_q];

endmodule

// File: tb/tb_vec_store_unit.sv
// Self-checking bench for vec_store_unit.
//
// A transaction-level model keeps a queue of expected word writes built from
// the register snapshot taken one cycle after an accepted request, and a
// single compare process checks every DUT output against it each cycle.
// Directed tests add literal expectations for latency, addresses and data.
module tb_vec_store_unit;

    localparam int LANES = 16;
    localparam int DW    = 8;
    localparam int RS    = 15;
    localparam int RSI   = 4;
    localparam int AW    = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [RSI-1:0]      vreg;
    logic [AW-1:0]       base_addr;
    logic                busy;
    logic                done;
    logic                error;
    logic [RSI-1:0]      rf_ra;
    logic [LANES*DW-1:0] rf_rd;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [31:0]         mem_wd;
    logic                mem_ready;

    always #5 clk = ~clk;

    vec_store_unit #(
        .LANES      (LANES),
        .DATAWIDTH  (DW),
        .REGSIZE    (RS),
        .REGSIZEINT (RSI),
        .ADDRWIDTH  (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .vreg      (vreg),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .rf_ra     (rf_ra),
        .rf_rd     (rf_rd),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_ready (mem_ready)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Word k of a store carries lanes 4k..4k+3, lane 4k in the low byte.
    function automatic logic [31:0] pack_beat(input logic [LANES*DW-1:0] v, input int k);
        logic [31:0] w;
        w = '0;
        for (int l = 0; l < 4; l++) begin
            logic [7:0] lane;
            lane = 8'((v >> (8 * (4 * k + l))) & 128'hFF);
            w    = w | (32'(lane) << (8 * l));
        end
        return w;
    endfunction

    // ---------------- model state ----------------
    bit          model_valid = 1'b0;
    bit          m_cap  = 1'b0;   // this cycle is the snapshot cycle
    bit          m_done = 1'b0;
    bit          m_err  = 1'b0;
    logic [3:0]  m_ra   = '0;
    logic [31:0] m_base = '0;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];

    // ---------------- observation ----------------
    int          cyc = 0;
    int          acc_cyc = 0;
    int          done_cyc = 0;
    bit          done_seen = 1'b0;
    logic [31:0] track_addr = 32'h1;
    int          track_cycles = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    // Compare, then advance the model with the inputs that the next edge sees.
    always @(negedge clk) begin
        cyc++;
        if (model_valid) begin
            check("busy", busy, m_cap || (q_addr.size() > 0) || m_done);
            check("done", done, m_done);
            check("error", error, m_err);
            check("mem_we", mem_we, q_addr.size() > 0);
            check("rf_ra", rf_ra, m_ra);
            if (q_addr.size() > 0) begin
                check("mem_addr", mem_addr, q_addr[0]);
                check("mem_wd", mem_wd, q_data[0]);
            end
        end
        if (mem_we === 1'b1 && mem_ready) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wd);
        end
        if (mem_we === 1'b1 && mem_addr == track_addr) track_cycles++;
        if (done === 1'b1) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end

        if (rst) begin
            model_valid = 1'b1;
            m_cap  = 1'b0;
            m_done = 1'b0;
            m_err  = 1'b0;
            m_ra   = '0;
            m_base = '0;
            q_addr.delete();
            q_data.delete();
        end else begin
            m_err = 1'b0;
            if (m_cap) begin
                for (int k = 0; k < 4; k++) begin
                    q_addr.push_back(m_base + 32'(4 * k));
                    q_data.push_back(pack_beat(rf_rd, k));
                end
                m_cap = 1'b0;
            end else if (q_addr.size() > 0) begin
                if (mem_ready) begin
                    void'(q_addr.pop_front());
                    void'(q_data.pop_front());
                    if (q_addr.size() == 0) m_done = 1'b1;
                end
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (start) begin
                if (int'(vreg) < RS && base_addr[1:0] == 2'b00) begin
                    m_cap   = 1'b1;
                    m_base  = base_addr;
                    m_ra    = vreg;
                    acc_cyc = cyc;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge; start is sampled at the following edge.
    task automatic start_store(input logic [3:0] v, input logic [31:0] b);
        done_seen = 1'b0;
        start     = 1'b1;
        vreg      = v;
        base_addr = b;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int n;
        n = 0;
        while (!done_seen && n < 40) begin
            tick();
            n++;
        end
        check({name, " done seen"}, done_seen, 1'b1);
        check({name, " latency"}, done_cyc - acc_cyc, exp_lat);
    endtask

    task automatic set_lanes_incr();
        for (int i = 0; i < LANES; i++) rf_rd[8*i +: 8] = 8'(i);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        vreg      = '0;
        base_addr = '0;
        mem_ready = 1'b1;
        set_lanes_incr();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst error", error, 1'b0);
        check("rst mem_we", mem_we, 1'b0);
        check("rst rf_ra", rf_ra, 4'd0);
        tick();

        // Basic store, zero wait states
        log_addr.delete();
        log_data.delete();
        start_store(4'd3, 32'h100);
        check("basic rf_ra", rf_ra, 4'd3);
        wait_done("basic", 6);
        check("basic nwr", log_addr.size(), 4);
        check("basic a0", log_addr[0], 32'h100);
        check("basic d0", log_data[0], 32'h03020100);
        check("basic a1", log_addr[1], 32'h104);
        check("basic d1", log_data[1], 32'h07060504);
        check("basic a2", log_addr[2], 32'h108);
        check("basic d2", log_data[2], 32'h0B0A0908);
        check("basic a3", log_addr[3], 32'h10C);
        check("basic d3", log_data[3], 32'h0F0E0D0C);

        // Back-to-back: issued in cycle 7; address wrap; rf_rd changes mid-write
        log_addr.delete();
        log_data.delete();
        start_store(4'd5, 32'hFFFF_FFF8);
        tick();
        rf_rd = ~rf_rd;
        wait_done("wrap", 6);
        set_lanes_incr();
        check("wrap nwr", log_addr.size(), 4);
        check("wrap a0", log_addr[0], 32'hFFFF_FFF8);
        check("wrap a1", log_addr[1], 32'hFFFF_FFFC);
        check("wrap a2", log_addr[2], 32'h0000_0000);
        check("wrap a3", log_addr[3], 32'h0000_0004);
        check("wrap d2", log_data[2], 32'h0B0A0908);
        check("wrap d3", log_data[3], 32'h0F0E0D0C);

        // Backpressure on beat 1 for two cycles
        log_addr.delete();
        log_data.delete();
        track_addr   = 32'h104;
        track_cycles = 0;
        start_store(4'd3, 32'h100);
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        mem_ready = 1'b1;
        wait_done("bp", 8);
        track_addr = 32'h1;
        check("bp beat1 held", track_cycles, 3);
        check("bp nwr", log_addr.size(), 4);
        check("bp d1", log_data[1], 32'h07060504);
        check("bp a3", log_addr[3], 32'h10C);

        // Rejected requests
        log_addr.delete();
        start_store(4'd15, 32'h100);
        @(negedge clk);
        check("rej vreg error", error, 1'b1);
        check("rej vreg we", mem_we, 1'b0);
        tick();
        @(negedge clk);
        check("rej vreg error 1cyc", error, 1'b0);
        tick();
        start_store(4'd2, 32'h102);
        @(negedge clk);
        check("rej align error", error, 1'b1);
        check("rej align busy", busy, 1'b0);
        tick();
        @(negedge clk);
        check("rej align error 1cyc", error, 1'b0);
        tick();
        tick();
        check("rej nwr", log_addr.size(), 0);

        // Start while busy is ignored
        log_addr.delete();
        start_store(4'd3, 32'h200);
        tick();
        start     = 1'b1;
        vreg      = 4'd15;
        base_addr = 32'h100;
        tick();
        vreg      = 4'd1;
        base_addr = 32'h300;
        tick();
        start = 1'b0;
        wait_done("ign", 6);
        tick();
        tick();
        @(negedge clk);
        check("ign busy after", busy, 1'b0);
        check("ign nwr", log_addr.size(), 4);
        check("ign a0", log_addr[0], 32'h200);
        tick();

        // Abort by reset after beat 1 accepted
        start_store(4'd4, 32'h400);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort mem_we", mem_we, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort rf_ra", rf_ra, 4'd0);
        tick();
        for (int i = 0; i < 10; i++) tick();
        check("abort no done", done_seen, 1'b0);

        // Reset wins over start in the same cycle
        rst       = 1'b1;
        start     = 1'b1;
        vreg      = 4'd2;
        base_addr = 32'h600;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst prio busy", busy, 1'b0);
        tick();

        // Normal store after the abort
        log_addr.delete();
        log_data.delete();
        start_store(4'd6, 32'h500);
        wait_done("post abort", 6);
        check("post nwr", log_addr.size(), 4);
        check("post a3", log_addr[3], 32'h50C);
        check("post d0", log_data[0], 32'h03020100);
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
